// File: rtl/agc_pkg.sv
// Shared AGC definitions: FSM states, fixed widths, gain constants and the common clamp helper.
package agc_pkg;

    localparam int unsigned LEVEL_WIDTH     = 48;
    localparam int unsigned FRAC_BITS       = 18;
    localparam int unsigned DWIDTH          = 27;
    localparam int unsigned GAIN_WIDTH      = 18;
    localparam int unsigned GAIN_FRAC       = 16;
    localparam int unsigned GAIN_ONE        = 65536;
    localparam int unsigned ERR_WIDTH       = 31;
    localparam int unsigned LEVEL_INT_WIDTH = LEVEL_WIDTH - FRAC_BITS;
    localparam int unsigned PROD_WIDTH      = DWIDTH + GAIN_WIDTH + 1;
    localparam int unsigned SUM_WIDTH       = 32;

    localparam logic signed [63:0] DATA_MAX_S = (64'sd1 <<< (DWIDTH - 1)) - 64'sd1;
    localparam logic signed [63:0] DATA_MIN_S = -(64'sd1 <<< (DWIDTH - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } agc_state_e;

    // Sample plus the gain it must be multiplied by, carried together through stage 1.
    typedef struct packed {
        logic signed [DWIDTH-1:0] data;
        logic [GAIN_WIDTH-1:0]    gain;
    } gain_sample_t;

    function automatic logic signed [63:0] sat_clamp(
        input logic signed [63:0] x,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        logic signed [63:0] r;
        r = x;
        if (x < lo) r = lo;
        if (x > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/agc_gain_control_if.sv
// Level-estimate, sample-stream and status signals of the AGC gain controller.
interface agc_gain_control_if;
    import agc_pkg::*;

    logic                          level_valid;
    logic signed [LEVEL_WIDTH-1:0] level;
    logic signed [DWIDTH-1:0]      target;
    logic                          freeze;
    logic                          data_valid;
    logic signed [DWIDTH-1:0]      data_in;
    logic                          data_valid_out;
    logic signed [DWIDTH-1:0]      data_out;
    logic [GAIN_WIDTH-1:0]         gain;
    logic                          locked;
    logic                          busy;

    modport master (
        output level_valid, level, target, freeze, data_valid, data_in,
        input  data_valid_out, data_out, gain, locked, busy
    );

    modport slave (
        input  level_valid, level, target, freeze, data_valid, data_in,
        output data_valid_out, data_out, gain, locked, busy
    );

endinterface

// File: rtl/agc_gain_apply.sv
// Two-stage sample gain path: capture sample+gain, then 27x18 multiply, floor shift and saturate.
module agc_gain_apply
    import agc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] in_data,
    input  logic [GAIN_WIDTH-1:0]    in_gain,
    output logic                     out_valid,
    output logic signed [DWIDTH-1:0] out_data
);

    logic                     s1_valid_q, s1_valid_d;
    gain_sample_t             s1_q, s1_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DWIDTH-1:0] out_data_q, out_data_d;

    logic signed [PROD_WIDTH-1:0] prod_c;
    logic signed [PROD_WIDTH-1:0] shr_c;
    logic signed [63:0]           shr_ext_c;
    logic signed [DWIDTH-1:0]     sat_data_c;

    // Gain is unsigned, so it enters the signed multiply with a zero sign bit.
    assign prod_c     = s1_q.data * $signed({1'b0, s1_q.gain});
    assign shr_c      = prod_c >>> GAIN_FRAC;
    assign shr_ext_c  = $signed({{(64 - PROD_WIDTH){shr_c[PROD_WIDTH-1]}}, shr_c});
    assign sat_data_c = DWIDTH'(sat_clamp(shr_ext_c, DATA_MIN_S, DATA_MAX_S));

    always_comb begin
        s1_valid_d  = in_valid;
        s1_d        = '{data: in_data, gain: in_gain};
        out_valid_d = s1_valid_q;
        out_data_d  = out_data_q;
        if (s1_valid_q) begin
            out_data_d = sat_data_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/agc_gain_control.sv
// AGC closed-loop gain controller: level error -> step integrator -> clamped Q2.16 gain, lock
// detection, and the gained sample stream.
module agc_gain_control
    import agc_pkg::*;
#(
    parameter int unsigned GAIN_INIT   = 65536,
    parameter int unsigned GAIN_MIN    = 256,
    parameter int unsigned GAIN_MAX    = 262143,
    parameter int unsigned STEP_SHIFT  = 8,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned LOCK_TOL    = 16,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    agc_gain_control_if.slave bus
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned LOCK_W = $clog2(LOCK_COUNT + 1);

    agc_state_e                  state_q, state_d;
    logic signed [ERR_WIDTH-1:0] err_q, err_d;
    logic [GAIN_WIDTH-1:0]       gain_q, gain_d;
    logic [LOCK_W-1:0]           lock_cnt_q, lock_cnt_d;
    logic                        locked_q, locked_d;
    logic [HOLD_W-1:0]           hold_cnt_q, hold_cnt_d;
    logic                        busy_q, busy_d;

    logic signed [LEVEL_INT_WIDTH-1:0] level_int_c;
    logic signed [ERR_WIDTH-1:0]       err_c;
    logic signed [ERR_WIDTH-1:0]       step_c;
    logic signed [SUM_WIDTH-1:0]       sum_c;
    logic signed [63:0]                sum_ext_c;
    logic [ERR_WIDTH-1:0]              abs_err_c;
    logic                              in_tol_c;
    logic                              unused_level_frac;

    // Integer part of the EMA level; both operands sign-extended so the difference cannot wrap.
    assign level_int_c = bus.level[LEVEL_WIDTH-1:FRAC_BITS];
    assign err_c = $signed({{(ERR_WIDTH - DWIDTH){bus.target[DWIDTH-1]}}, bus.target})
                 - $signed({{(ERR_WIDTH - LEVEL_INT_WIDTH){level_int_c[LEVEL_INT_WIDTH-1]}}, level_int_c});
    assign unused_level_frac = ^bus.level[FRAC_BITS-1:0];

    assign step_c    = err_q >>> STEP_SHIFT;
    assign sum_c     = $signed({{(SUM_WIDTH - ERR_WIDTH){step_c[ERR_WIDTH-1]}}, step_c})
                     + $signed(SUM_WIDTH'(gain_q));
    assign sum_ext_c = $signed({{(64 - SUM_WIDTH){sum_c[SUM_WIDTH-1]}}, sum_c});
    assign abs_err_c = err_q[ERR_WIDTH-1] ? ERR_WIDTH'(-err_q) : ERR_WIDTH'(err_q);
    assign in_tol_c  = (abs_err_c <= ERR_WIDTH'(LOCK_TOL));

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        gain_d     = gain_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.level_valid && !bus.freeze) begin
                    err_d   = err_c;
                    state_d = CALC;
                end
            end
            CALC: begin
                gain_d = GAIN_WIDTH'(sat_clamp(sum_ext_c, 64'(GAIN_MIN), 64'(GAIN_MAX)));
                if (in_tol_c) begin
                    if (lock_cnt_q != LOCK_W'(LOCK_COUNT)) begin
                        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                    end
                end else begin
                    lock_cnt_d = '0;
                end
                locked_d   = (lock_cnt_d == LOCK_W'(LOCK_COUNT));
                hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
                state_d    = HOLD;
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            err_q      <= '0;
            gain_q     <= GAIN_WIDTH'(GAIN_INIT);
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            gain_q     <= gain_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            hold_cnt_q <= hold_cnt_d;
            busy_q     <= busy_d;
        end
    end

    logic                     dp_valid;
    logic signed [DWIDTH-1:0] dp_data;

    agc_gain_apply u_apply (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.data_valid),
        .in_data   (bus.data_in),
        .in_gain   (gain_q),
        .out_valid (dp_valid),
        .out_data  (dp_data)
    );

    assign bus.data_valid_out = dp_valid;
    assign bus.data_out       = dp_data;
    assign bus.gain           = gain_q;
    assign bus.locked         = locked_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_agc_gain_control.sv
// Directed bench for agc_gain_control with hand-computed expectations.
module tb_agc_gain_control;
    import agc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    agc_gain_control_if bus ();

    agc_gain_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_level(input longint tgt, input longint lvl_int);
        bus.target      = DWIDTH'(tgt);
        bus.level       = LEVEL_WIDTH'(lvl_int) << FRAC_BITS;
        bus.level_valid = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        check("idle_wait", longint'(bus.busy), 0);
    endtask

    // One accepted update; returns at the negedge after the CALC edge, then waits for IDLE.
    task automatic do_update(input longint tgt, input longint lvl_int);
        tick();
        drive_level(tgt, lvl_int);
        tick();
        bus.level_valid = 1'b0;
        tick();
        wait_idle();
    endtask

    task automatic lock_round(input string tag, input longint err, input longint exp_pre,
                              input longint exp_post);
        tick();
        drive_level(500 + err, 500);
        tick();
        bus.level_valid = 1'b0;
        check({tag, "_pre"}, longint'(bus.locked), exp_pre);
        tick();
        check({tag, "_post"}, longint'(bus.locked), exp_post);
        wait_idle();
    endtask

    longint ins [3] = '{67108863, -67108864, -3};
    longint outs[3] = '{67108863, -67108864, -6};

    initial begin
        int first_low;
        int first_chg;

        bus.level_valid = 1'b0;
        bus.level       = '0;
        bus.target      = '0;
        bus.freeze      = 1'b0;
        bus.data_valid  = 1'b0;
        bus.data_in     = '0;

        repeat (2) tick();
        check("rst_gain", longint'(bus.gain), 65536);
        check("rst_dvo", longint'(bus.data_valid_out), 0);
        check("rst_dout", longint'($signed(bus.data_out)), 0);
        check("rst_locked", longint'(bus.locked), 0);
        check("rst_busy", longint'(bus.busy), 0);
        rst_n = 1'b1;
        tick();

        // Small step (+1), then hold level_valid high to find the earliest re-accept.
        drive_level(1000, 744);
        tick();
        check("step_busy", longint'(bus.busy), 1);
        check("step_gain_pre", longint'(bus.gain), 65536);
        drive_level(1000, 488);
        first_low = 0;
        first_chg = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) check("step_gain", longint'(bus.gain), 65537);
            if (first_low == 0 && !bus.busy) first_low = i;
            if (first_chg == 0 && bus.gain != 18'd65537) begin
                first_chg = i;
                break;
            end
        end
        bus.level_valid = 1'b0;
        check("busy_len", first_low, 17);
        check("reaccept", first_chg, 19);
        check("reaccept_gain", longint'(bus.gain), 65539);
        wait_idle();

        do_update(0, 768);
        check("gain_unity", longint'(bus.gain), 65536);

        tick();
        bus.data_in    = DWIDTH'(12345);
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        check("dp_lat1_valid", longint'(bus.data_valid_out), 0);
        tick();
        check("dp_lat2_valid", longint'(bus.data_valid_out), 1);
        check("dp_unity", longint'($signed(bus.data_out)), 12345);
        tick();
        check("dp_after_valid", longint'(bus.data_valid_out), 0);
        check("dp_hold", longint'($signed(bus.data_out)), 12345);

        do_update(1 << 24, 0);
        check("gain_two", longint'(bus.gain), 131072);

        for (int k = 0; k < 5; k++) begin
            tick();
            if (k >= 2) begin
                check("dp2_valid", longint'(bus.data_valid_out), 1);
                check("dp2_data", longint'($signed(bus.data_out)), outs[k-2]);
            end
            if (k < 3) begin
                bus.data_in    = DWIDTH'(ins[k]);
                bus.data_valid = 1'b1;
            end else begin
                bus.data_valid = 1'b0;
            end
        end

        // Samples captured up to and including the update edge use the old gain.
        tick();
        bus.data_in    = DWIDTH'(100);
        bus.data_valid = 1'b1;
        drive_level(0, 1 << 24);
        tick();
        bus.level_valid = 1'b0;
        tick();
        check("order_pre", longint'($signed(bus.data_out)), 200);
        tick();
        check("order_edge", longint'($signed(bus.data_out)), 200);
        tick();
        check("order_post", longint'($signed(bus.data_out)), 100);
        bus.data_valid = 1'b0;
        check("order_gain", longint'(bus.gain), 65536);
        wait_idle();

        do_update((1 << 26) - 1, 0);
        check("clamp_max", longint'(bus.gain), 262143);
        do_update(-(1 << 26), (1 << 29) - 1);
        check("clamp_min", longint'(bus.gain), 256);

        // level_valid held through CALC and all of HOLD: only the first is taken.
        tick();
        drive_level(1000, 744);
        repeat (17) tick();
        bus.level_valid = 1'b0;
        wait_idle();
        repeat (3) tick();
        check("drop_gain", longint'(bus.gain), 257);

        bus.freeze = 1'b1;
        drive_level(1000, 0);
        tick();
        bus.level_valid = 1'b0;
        check("freeze_busy", longint'(bus.busy), 0);
        repeat (2) tick();
        check("freeze_gain", longint'(bus.gain), 257);
        bus.freeze = 1'b0;

        lock_round("lock1", 0, 0, 0);
        lock_round("lock2", 16, 0, 0);
        lock_round("lock3", -16, 0, 0);
        lock_round("lock4", 0, 0, 1);
        lock_round("unlock", 100, 1, 0);
        lock_round("relock1", 0, 0, 0);
        lock_round("relock2", 0, 0, 0);
        lock_round("relock3", 0, 0, 0);
        lock_round("relock4", 0, 0, 1);

        // Asynchronous reset in the middle of an update and a sample burst.
        tick();
        bus.data_in    = DWIDTH'(5);
        bus.data_valid = 1'b1;
        drive_level(1000, 744);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gain", longint'(bus.gain), 65536);
        check("mid_rst_dvo", longint'(bus.data_valid_out), 0);
        check("mid_rst_dout", longint'($signed(bus.data_out)), 0);
        check("mid_rst_locked", longint'(bus.locked), 0);
        check("mid_rst_busy", longint'(bus.busy), 0);
        bus.level_valid = 1'b0;
        bus.data_valid  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", longint'(bus.busy), 0);
        check("post_rst_dvo", longint'(bus.data_valid_out), 0);
        do_update(1000, 744);
        check("post_rst_gain", longint'(bus.gain), 65537);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
